// File: rtl/quad_encoder_speed.sv
// Multi-channel quadrature decoder: synchronised A/B inputs, position counters,
// windowed signed speed and sticky illegal-transition flags. Glitch filter: QENC_GLITCH_FILTER_EN.
module quad_encoder_speed #(
    parameter int NUM_CH        = 4,
    parameter int COUNT_W       = 16,
    parameter int SPEED_W       = 16,
    parameter int WINDOW_CYCLES = 50000,
    parameter int FILTER_LEN    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*NUM_CH-1:0]         enc,
    input  logic [NUM_CH-1:0]           clear_count,
    input  logic                        error_clear,
    output logic [NUM_CH*COUNT_W-1:0]   enc_count,
    output logic [NUM_CH*SPEED_W-1:0]   speed,
    output logic                        speed_valid,
    output logic [NUM_CH-1:0]           enc_error
);

    localparam int ACC_W = SPEED_W + 1;
    localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {SPEED_W{1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {SPEED_W{1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE  = {{SPEED_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ACC_NEG1 = '1;
    localparam logic signed [ACC_W-1:0] SPD_MAX  = {2'b00, {(SPEED_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SPD_MIN  = {2'b11, {(SPEED_W-1){1'b0}}};

    logic [1:0]              r_sync1 [NUM_CH];
    logic [1:0]              r_sync2 [NUM_CH];
    logic [1:0]              r_qprev [NUM_CH];
    logic [1:0]              w_q     [NUM_CH];
    logic [NUM_CH-1:0]       w_up, w_dn, w_ill;
    logic [COUNT_W-1:0]      r_count [NUM_CH];
    logic signed [ACC_W-1:0] r_acc   [NUM_CH];
    logic [SPEED_W-1:0]      r_speed [NUM_CH];
    logic [NUM_CH-1:0]       r_error;
    logic [WIN_W-1:0]        r_win;
    logic                    r_valid;
    logic                    w_last;

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic up, input logic dn);
        logic signed [ACC_W-1:0] r;
        r = a;
        if (up && a != ACC_MAX)
            r = a + ACC_ONE;
        else if (dn && a != ACC_MIN)
            r = a - ACC_ONE;
        return r;
    endfunction

    function automatic logic [SPEED_W-1:0] sat_speed(input logic signed [ACC_W-1:0] a);
        logic [SPEED_W-1:0] r;
        if (a > SPD_MAX)
            r = SPD_MAX[SPEED_W-1:0];
        else if (a < SPD_MIN)
            r = SPD_MIN[SPEED_W-1:0];
        else
            r = a[SPEED_W-1:0];
        return r;
    endfunction

    // Front end keeps tracking the pins through reset so release is glitch-free.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_sync1[i] <= enc[2*i +: 2];
            r_sync2[i] <= r_sync1[i];
            r_qprev[i] <= reset ? r_sync2[i] : w_q[i];
        end
    end

`ifdef QENC_GLITCH_FILTER_EN
    localparam int HIST_D = FILTER_LEN - 1;
    logic [1:0] r_hist [NUM_CH][HIST_D];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_hist[i][0] <= r_sync2[i];
            for (int unsigned j = 1; j < HIST_D; j++)
                r_hist[i][j] <= r_hist[i][j-1];
        end
    end

    // The live synchroniser output counts as the newest of the FILTER_LEN samples.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_q[i] = r_sync2[i];
            for (int unsigned j = 0; j < HIST_D; j++)
                if (r_hist[i][j] != r_sync2[i])
                    w_q[i] = r_qprev[i];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++)
            w_q[i] = r_sync2[i];
    end
`endif

    always_comb begin
        w_up  = '0;
        w_dn  = '0;
        w_ill = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case ({r_qprev[i], w_q[i]})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up[i]  = 1'b1;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: w_dn[i]  = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: w_ill[i] = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_last = (r_win == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_last;
            r_win   <= w_last ? '0 : r_win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_count[i] <= '0;
                r_acc[i]   <= '0;
                r_speed[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (clear_count[i])
                    r_count[i] <= '0;
                else if (w_up[i])
                    r_count[i] <= r_count[i] + 1'b1;
                else if (w_dn[i])
                    r_count[i] <= r_count[i] - 1'b1;

                if (w_ill[i])
                    r_error[i] <= 1'b1;
                else if (error_clear)
                    r_error[i] <= 1'b0;

                // A step landing in the last window cycle opens the next window.
                if (w_last) begin
                    r_speed[i] <= sat_speed(r_acc[i]);
                    r_acc[i]   <= w_up[i] ? ACC_ONE : (w_dn[i] ? ACC_NEG1 : '0);
                end else begin
                    r_acc[i]   <= sat_add(r_acc[i], w_up[i], w_dn[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign enc_count[g*COUNT_W +: COUNT_W] = r_count[g];
        assign speed[g*SPEED_W +: SPEED_W]     = r_speed[g];
    end

    assign enc_error   = r_error;
    assign speed_valid = r_valid;

endmodule
